// File: rtl/brisc_pkg.sv
// Shared definitions for the BRISC-V integer register file and its busy scoreboard.
// Register indices are 5 bits wide; x0 is hardwired to zero and x2 is the stack pointer.
package brisc_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;
    localparam int COUNT_WIDTH    = 6;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd0;
    localparam reg_idx_t SP_REG   = 5'd2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking for outstanding long-latency producers (loads).
// Supplies busy flags for both decode sources and a registered count of busy registers.
module regfile_scoreboard
    import brisc_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   write,
    input  reg_idx_t               write_reg,
    input  logic                   issue_valid,
    input  reg_idx_t               issue_reg,
    input  reg_idx_t               read_sel1,
    input  reg_idx_t               read_sel2,
    output logic                   busy1,
    output logic                   busy2,
    output logic [COUNT_WIDTH-1:0] busy_count
);

    // issue_valid is a one-cycle pulse with no ready: decode only raises it
    // after the stall logic has cleared the instruction, so it is always taken.
    logic [NUM_REGS-1:0]    busy_q;
    logic [NUM_REGS-1:0]    busy_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   clr_hit;
    logic                   set_hit;
    logic                   rise;
    logic                   fall;

    always_comb begin
        clr_hit = write && (write_reg != ZERO_REG);
        set_hit = issue_valid && (issue_reg != ZERO_REG);

        busy_d = busy_q;
        if (clr_hit) begin
            busy_d[write_reg] = 1'b0;
        end
        // A new producer supersedes the one completing in the same cycle.
        if (set_hit) begin
            busy_d[issue_reg] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;

        rise    = set_hit && !busy_q[issue_reg];
        fall    = clr_hit && busy_q[write_reg] && !(set_hit && (issue_reg == write_reg));
        count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, rise} - {{(COUNT_WIDTH-1){1'b0}}, fall};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // A write completing this cycle satisfies the read through the bypass.
    always_comb begin
        busy1 = busy_q[read_sel1] && !(write && (write_reg == read_sel1)) && (read_sel1 != ZERO_REG);
        busy2 = busy_q[read_sel2] && !(write && (write_reg == read_sel2)) && (read_sel2 != ZERO_REG);
    end

    assign busy_count = count_q;

endmodule

// File: rtl/regfile_unit.sv
// Architectural register file: writeback write port, two bypassed decode read ports,
// and a busy scoreboard that raises a hazard toward the stall logic.
module regfile_unit
    import brisc_pkg::*;
#(
    parameter int                    CORE       = 0,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = DATA_WIDTH'(32'h0000_0FFC)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             read_sel1,
    input  logic [4:0]             read_sel2,
    output logic [DATA_WIDTH-1:0]  read_data1,
    output logic [DATA_WIDTH-1:0]  read_data2,
    input  logic                   write,
    input  logic [4:0]             write_reg,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   issue_valid,
    input  logic [4:0]             issue_reg,
    output logic                   busy1,
    output logic                   busy2,
    output logic                   hazard,
    output logic [5:0]             busy_count
);

    // CORE only tags the instance in multi-core builds; negative indices are meaningless.
    if (CORE < 0) begin : g_invalid_core
    end

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  bypass1;
    logic                  bypass2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == int'(SP_REG)) ? SP_INIT : '0;
            end
        end else if (write && (write_reg != ZERO_REG)) begin
            regs[write_reg] <= write_data;
        end
    end

    // While reset is held the ports show the reset contents, not in-flight writes.
    always_comb begin
        bypass1 = !reset && write && (write_reg == read_sel1);
        bypass2 = !reset && write && (write_reg == read_sel2);

        read_data1 = regs[read_sel1];
        if (read_sel1 == ZERO_REG) begin
            read_data1 = '0;
        end else if (bypass1) begin
            read_data1 = write_data;
        end

        read_data2 = regs[read_sel2];
        if (read_sel2 == ZERO_REG) begin
            read_data2 = '0;
        end else if (bypass2) begin
            read_data2 = write_data;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .write       (write),
        .write_reg   (write_reg),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .read_sel1   (read_sel1),
        .read_sel2   (read_sel2),
        .busy1       (busy1),
        .busy2       (busy2),
        .busy_count  (busy_count)
    );

    assign hazard = busy1 | busy2;

endmodule

// File: tb/tb_regfile_unit.sv
// Bench for regfile_unit: directed vector table, hand-written reset sequence,
// then randomized traffic checked against an array-based reference model.
module tb_regfile_unit;

    localparam logic [31:0] SP = 32'h0000_0FFC;

    logic        clock;
    logic        reset;
    logic [4:0]  read_sel1, read_sel2;
    logic [31:0] read_data1, read_data2;
    logic        write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic        busy1, busy2, hazard;
    logic [5:0]  busy_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [31:0] exp_q [$];

    typedef struct {
        logic        wr;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        iv;
        logic [4:0]  ireg;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic        e_hz;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs [14];

    regfile_unit #(.CORE(0), .DATA_WIDTH(32), .SP_INIT(SP)) dut (
        .clock       (clock),
        .reset       (reset),
        .read_sel1   (read_sel1),
        .read_sel2   (read_sel2),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .write       (write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .busy1       (busy1),
        .busy2       (busy2),
        .hazard      (hazard),
        .busy_count  (busy_count)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model
    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_regs[2] = SP;
    endtask

    task automatic model_update();
        if (write && write_reg != 0) begin
            m_regs[write_reg] = write_data;
            m_busy[write_reg] = 1'b0;
        end
        if (issue_valid && issue_reg != 0) m_busy[issue_reg] = 1'b1;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] sel);
        if (sel == 0) return 32'h0;
        if (write && write_reg == sel) return write_data;
        return m_regs[sel];
    endfunction

    function automatic logic model_busy(input logic [4:0] sel);
        return sel != 0 && m_busy[sel] && !(write && write_reg == sel);
    endfunction

    function automatic logic [5:0] model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return 6'(n);
    endfunction

    // Driver
    task automatic drive(input logic wr, input logic [4:0] wreg, input logic [31:0] wdata,
                         input logic iv, input logic [4:0] ireg,
                         input logic [4:0] s1, input logic [4:0] s2);
        write = wr; write_reg = wreg; write_data = wdata;
        issue_valid = iv; issue_reg = ireg;
        read_sel1 = s1; read_sel2 = s2;
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else model_update();
    endtask

    initial begin
        //                wr    wreg   wdata          iv    ireg   s1     s2     rd1            rd2           b1    b2    hz    cnt
        vecs[0]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  5'd2, 5'd0,  SP,            32'h0,        1'b0, 1'b0, 1'b0, 6'd0};
        vecs[1]  = '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0,  5'd5, 5'd2,  32'hDEAD_BEEF, SP,           1'b0, 1'b0, 1'b0, 6'd0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  5'd5, 5'd0,  32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0, 1'b0, 6'd0};
        vecs[3]  = '{1'b1, 5'd0, 32'h1234,      1'b1, 5'd0,  5'd0, 5'd0,  32'h0,         32'h0,        1'b0, 1'b0, 1'b0, 6'd0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  5'd0, 5'd5,  32'h0,         32'hDEAD_BEEF,1'b0, 1'b0, 1'b0, 6'd0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd7,  5'd7, 5'd7,  32'h0,         32'h0,        1'b0, 1'b0, 1'b0, 6'd0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  5'd0, 5'd7,  32'h0,         32'h0,        1'b0, 1'b1, 1'b1, 6'd1};
        vecs[7]  = '{1'b1, 5'd7, 32'h55,        1'b0, 5'd0,  5'd0, 5'd7,  32'h0,         32'h55,       1'b0, 1'b0, 1'b0, 6'd1};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  5'd0, 5'd7,  32'h0,         32'h55,       1'b0, 1'b0, 1'b0, 6'd0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9,  5'd9, 5'd0,  32'h0,         32'h0,        1'b0, 1'b0, 1'b0, 6'd0};
        vecs[10] = '{1'b1, 5'd9, 32'hAA,        1'b1, 5'd9,  5'd9, 5'd0,  32'hAA,        32'h0,        1'b0, 1'b0, 1'b0, 6'd1};
        vecs[11] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  5'd9, 5'd0,  32'hAA,        32'h0,        1'b1, 1'b0, 1'b1, 6'd1};
        vecs[12] = '{1'b1, 5'd9, 32'hBB,        1'b1, 5'd10, 5'd9, 5'd10, 32'hBB,        32'h0,        1'b0, 1'b0, 1'b0, 6'd1};
        vecs[13] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  5'd9, 5'd10, 32'hBB,        32'h0,        1'b0, 1'b1, 1'b1, 6'd1};

        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        model_reset();
        repeat (2) tick();
        @(negedge clock);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            drive(vecs[i].wr, vecs[i].wreg, vecs[i].wdata, vecs[i].iv, vecs[i].ireg, vecs[i].s1, vecs[i].s2);
            #2;
            check($sformatf("vec%0d_rd1", i), read_data1, vecs[i].e_rd1);
            check($sformatf("vec%0d_rd2", i), read_data2, vecs[i].e_rd2);
            check($sformatf("vec%0d_busy1", i), 32'(busy1), 32'(vecs[i].e_b1));
            check($sformatf("vec%0d_busy2", i), 32'(busy2), 32'(vecs[i].e_b2));
            check($sformatf("vec%0d_hazard", i), 32'(hazard), 32'(vecs[i].e_hz));
            check($sformatf("vec%0d_count", i), 32'(busy_count), 32'(vecs[i].e_cnt));
            tick();
        end

        // Three busy registers (10, 11, 12), then asynchronous reset between edges
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 5'd0, 5'd0);
        tick();
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd0, 5'd0);
        tick();
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd10);
        #2;
        check("pre_reset_count", 32'(busy_count), 32'd3);
        check("pre_reset_rd_x5", read_data1, 32'hDEAD_BEEF);
        check("pre_reset_hazard", 32'(hazard), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_reset_count", 32'(busy_count), 32'd0);
        check("async_reset_hazard", 32'(hazard), 32'd0);
        check("async_reset_rd_x5", read_data1, 32'h0);
        read_sel1 = 5'd2;
        #1;
        check("async_reset_rd_sp", read_data1, SP);
        // Write and issue presented while reset is held must not survive
        drive(1'b1, 5'd6, 32'h77, 1'b1, 5'd13, 5'd6, 5'd13);
        tick();
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd13);
        #2;
        check("post_reset_rd_x6", read_data1, 32'h0);
        check("post_reset_busy2", 32'(busy2), 32'd0);
        check("post_reset_count", 32'(busy_count), 32'd0);
        tick();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #2;
            exp_q.push_back(model_read(read_sel1));
            exp_q.push_back(model_read(read_sel2));
            check("rand_rd1", read_data1, exp_q.pop_front());
            check("rand_rd2", read_data2, exp_q.pop_front());
            check("rand_busy1", 32'(busy1), 32'(model_busy(read_sel1)));
            check("rand_busy2", 32'(busy2), 32'(model_busy(read_sel2)));
            check("rand_hazard", 32'(hazard), 32'(model_busy(read_sel1) | model_busy(read_sel2)));
            check("rand_count", 32'(busy_count), 32'(model_count()));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
